// File: rtl/cursor_ctrl.sv
// Cursor position and blink engine for the VT52 text pipeline.
// Optional macro CURSOR_SAVE_RESTORE_EN adds SAVE/RESTORE of the cursor position.
module cursor_ctrl #(
  parameter int ROW_BITS    = 5,
  parameter int COL_BITS    = 7,
  parameter int ROWS        = 24,
  parameter int COLS        = 80,
  parameter int BLINK_TICKS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                blink_enable,
  input  logic                cmd_valid,
  input  logic [3:0]          cmd_op,
  input  logic [COL_BITS-1:0] new_x,
  input  logic [ROW_BITS-1:0] new_y,
  output logic [COL_BITS-1:0] x,
  output logic [ROW_BITS-1:0] y,
  output logic                blink_on,
  output logic                scroll_req
);

  localparam logic [3:0] OP_SET     = 4'd1;
  localparam logic [3:0] OP_UP      = 4'd2;
  localparam logic [3:0] OP_DOWN    = 4'd3;
  localparam logic [3:0] OP_LEFT    = 4'd4;
  localparam logic [3:0] OP_RIGHT   = 4'd5;
  localparam logic [3:0] OP_HOME    = 4'd6;
  localparam logic [3:0] OP_CR      = 4'd7;
  localparam logic [3:0] OP_LF      = 4'd8;
  localparam logic [3:0] OP_SAVE    = 4'd9;
  localparam logic [3:0] OP_RESTORE = 4'd10;

  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [COL_BITS-1:0] X_MAX    = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] Y_MAX    = ROW_BITS'(ROWS - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BLINK_TICKS - 1);

  logic [COL_BITS-1:0] x_nxt;
  logic [ROW_BITS-1:0] y_nxt;
  logic                scroll_nxt;
  logic                cmd_active;
  logic [CNT_W-1:0]    blink_cnt;

`ifdef CURSOR_SAVE_RESTORE_EN
  logic [COL_BITS-1:0] save_x;
  logic [ROW_BITS-1:0] save_y;
`endif

  // Every clamp compares against the visible-area limits, never relying on wrap-around.
  always_comb begin
    x_nxt      = x;
    y_nxt      = y;
    scroll_nxt = 1'b0;
    cmd_active = 1'b0;
    if (cmd_valid) begin
      case (cmd_op)
        OP_SET: begin
          cmd_active = 1'b1;
          x_nxt = (new_x > X_MAX) ? X_MAX : new_x;
          y_nxt = (new_y > Y_MAX) ? Y_MAX : new_y;
        end
        OP_UP: begin
          cmd_active = 1'b1;
          if (y != '0) y_nxt = y - 1'b1;
        end
        OP_DOWN: begin
          cmd_active = 1'b1;
          if (y < Y_MAX) y_nxt = y + 1'b1;
        end
        OP_LEFT: begin
          cmd_active = 1'b1;
          if (x != '0) x_nxt = x - 1'b1;
        end
        OP_RIGHT: begin
          cmd_active = 1'b1;
          if (x < X_MAX) x_nxt = x + 1'b1;
        end
        OP_HOME: begin
          cmd_active = 1'b1;
          x_nxt = '0;
          y_nxt = '0;
        end
        OP_CR: begin
          cmd_active = 1'b1;
          x_nxt = '0;
        end
        OP_LF: begin
          cmd_active = 1'b1;
          if (y < Y_MAX) y_nxt = y + 1'b1;
          else           scroll_nxt = 1'b1;
        end
`ifdef CURSOR_SAVE_RESTORE_EN
        OP_SAVE: begin
          cmd_active = 1'b1;
        end
        OP_RESTORE: begin
          cmd_active = 1'b1;
          x_nxt = save_x;
          y_nxt = save_y;
        end
`endif
        default: begin
          cmd_active = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      scroll_req <= 1'b0;
    end else begin
      x          <= x_nxt;
      y          <= y_nxt;
      scroll_req <= scroll_nxt;
    end
  end

`ifdef CURSOR_SAVE_RESTORE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      save_x <= '0;
      save_y <= '0;
    end else if (cmd_valid && cmd_op == OP_SAVE) begin
      save_x <= x;
      save_y <= y;
    end
  end
`endif

  // A command restarts the visible phase even if a tick lands on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!blink_enable || cmd_active) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/cursor_ctrl.md
Name: cursor_ctrl

Overview:
Cursor position and blink engine for the VT52 text pipeline. It accepts one-cycle cursor commands: absolute set, relative moves, home, carriage return and line feed. The position is clamped to a parametrised screen size, and a scroll request is raised when a line feed hits the bottom row. It sits between the escape-sequence/command decoder and the video renderer, which consumes x, y and blink_on.

Parameters:
ROW_BITS, 5, width of row coordinate
COL_BITS, 7, width of column coordinate
ROWS, 24, number of visible rows (1..2^ROW_BITS)
COLS, 80, number of visible columns (1..2^COL_BITS)
BLINK_TICKS, 16, ticks per blink half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle blink timebase pulse (e.g. per frame)
blink_enable  in  1  1 = cursor blinks; 0 = cursor held visible
cmd_valid  in  1  command strobe, one cycle per command
cmd_op  in  4  opcode: 0 NOP, 1 SET, 2 UP, 3 DOWN, 4 LEFT, 5 RIGHT, 6 HOME, 7 CR, 8 LF, 9 SAVE, 10 RESTORE, 11-15 NOP
new_x  in  COL_BITS  column for SET
new_y  in  ROW_BITS  row for SET
x  out  COL_BITS  current cursor column
y  out  ROW_BITS  current cursor row
blink_on  out  1  cursor visible phase
scroll_req  out  1  one-cycle pulse: LF issued on last row

Behaviour:
- Reset (async, active-high) forces x=0, y=0, blink_on=1, scroll_req=0, blink counter=0, saved position=(0,0).
- All outputs are registered. An accepted command changes x/y on the first rising edge with cmd_valid=1; the new value is visible next cycle. There is no ready signal: every command is accepted.
- SET: x=min(new_x, COLS-1), y=min(new_y, ROWS-1).
- UP: y=y-1; at y=0 stays 0.
- DOWN: y=y+1; at ROWS-1 stays.
- LEFT: x=x-1; at x=0 stays.
- RIGHT: x=x+1; at COLS-1 stays. No wrap to the next line.
- HOME: x=0, y=0.
- CR: x=0, y unchanged.
- LF: y=y+1 if y<ROWS-1. Otherwise y unchanged and scroll_req=1 for exactly one cycle. x is unchanged.
- NOP and reserved opcodes: no state change of any kind.
- Blink counter:
  - When blink_enable=1 and tick=1: if counter==BLINK_TICKS-1, set counter=0 and toggle blink_on; otherwise counter+1.
  - When blink_enable=0: counter=0 and blink_on=1, every cycle.
- Any accepted non-NOP command (including clamped no-movement moves) sets counter=0 and blink_on=1 that edge. This has priority over a coincident tick, so cursor motion is always immediately visible.
- All arithmetic is done at the coordinate width. Clamp comparisons use the constants ROWS-1 and COLS-1, never wrap-around. Position must never exceed ROWS-1/COLS-1 under any command sequence.
- Reset asserted mid-command: reset wins, the command is lost, and no scroll_req is emitted.

Optional Feature:
CURSOR_SAVE_RESTORE_EN
- Defined: SAVE copies (x,y) into a save register. RESTORE loads (x,y) from the save register. Both reset the blink counter as normal commands. The save register resets to (0,0).
- Not defined: opcodes 9 and 10 act as NOP (no blink reset) and no save register is built.

Test Plan:
- Reset, then SET new_x=100, new_y=30 (80x24) -> x=79, y=23; blink_on=1.
- At (0,0): UP, LEFT -> (0,0). SET (79,23) then RIGHT, DOWN -> (79,23), scroll_req stays 0.
- At y=23: LF -> y=23, scroll_req high exactly 1 cycle. At y=5: LF -> y=6, scroll_req=0.
- Blink, BLINK_TICKS=4: 4 ticks -> blink_on=0; 4 more -> 1. Next, RIGHT on the same cycle as the 4th tick of a phase -> blink_on=1, counter=0, no toggle.
- blink_enable=0 for 20 ticks -> blink_on constant 1. Async reset pulsed mid-sequence at (40,10) -> (0,0) immediately, without waiting for a clock edge.
- CURSOR_SAVE_RESTORE_EN defined: SET(12,7), SAVE, HOME, RESTORE -> (12,7). Macro undefined: the same sequence ends at (0,0).
